// File: rtl/p405s_scbd_pkg.sv
// Shared definitions for the GPR hazard scoreboard: default geometry and
// the per-stage in-flight entry record.
package p405s_scbd_pkg;

    localparam int SCBD_AW     = 5;  // register-file address width
    localparam int SCBD_NRP    = 3;  // read ports compared (A, B, S)
    localparam int SCBD_NST    = 4;  // tracked in-flight stages, 0 = exe
    localparam int SCBD_LDRDY  = 2;  // first stage where load data can bypass
    localparam int SCBD_AW_MAX = 8;  // widest address an entry can hold (AW <= 8)

    // One in-flight destination: valid, register address, written-by-load.
    typedef struct packed {
        logic                   vld;
        logic [SCBD_AW_MAX-1:0] addr;
        logic                   ld;
    } scbd_entry_t;

    localparam scbd_entry_t SCBD_ENTRY_EMPTY = '{vld: 1'b0, addr: '0, ld: 1'b0};

endpackage

// File: rtl/p405s_gpr_hazard_scbd_if.sv
// Decode/scoreboard bundle: decode-side issue request, read-port lookups,
// pipeline control, and the bypass/stall answers.
interface p405s_gpr_hazard_scbd_if
    import p405s_scbd_pkg::*;
#(
    parameter int AW  = SCBD_AW,
    parameter int NRP = SCBD_NRP,
    parameter int NST = SCBD_NST
);
    logic               dcdValid;
    logic               dcdWrEn;
    logic [AW-1:0]      dcdWrAddr;
    logic               dcdIsLoad;
    logic [NRP-1:0]     rdEn;
    logic [NRP*AW-1:0]  rdAddr;
    logic               holdExe;
    logic               flushAll;
    logic [NRP-1:0]     bypHit;
    logic [NRP*NST-1:0] bypSel;
    logic               stallReq;
    logic               issueAck;

    // Decode stage side.
    modport master (
        output dcdValid, dcdWrEn, dcdWrAddr, dcdIsLoad, rdEn, rdAddr, holdExe, flushAll,
        input  bypHit, bypSel, stallReq, issueAck
    );

    // Scoreboard side.
    modport slave (
        input  dcdValid, dcdWrEn, dcdWrAddr, dcdIsLoad, rdEn, rdAddr, holdExe, flushAll,
        output bypHit, bypSel, stallReq, issueAck
    );
endinterface

// File: rtl/p405s_scbd_portcmp.sv
// One read port against all in-flight stages: finds the youngest matching
// stage and reports either a bypass select or a stall if it is not ready.
module p405s_scbd_portcmp
    import p405s_scbd_pkg::*;
#(
    parameter int AW    = SCBD_AW,
    parameter int NST   = SCBD_NST,
    parameter int LDRDY = SCBD_LDRDY
)(
    input  logic                    rd_en_i,
    input  logic [AW-1:0]           rd_addr_i,
    input  scbd_entry_t [NST-1:0]   stages_i,
    output logic                    hit_o,
    output logic [NST-1:0]          sel_o,
    output logic                    stall_o
);
    logic           found;
    logic           ready;
    logic [NST-1:0] pick;

    // Walk oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        // NOTE: every variable gets a default before the loop, so no path leaves one unassigned (no latch).
        found = 1'b0;
        ready = 1'b0;
        pick  = '0;
        for (int k = NST - 1; k >= 0; k--) begin
            if (rd_en_i && stages_i[k].vld && (stages_i[k].addr == SCBD_AW_MAX'(rd_addr_i))) begin
                found   = 1'b1;
                pick    = '0;
                pick[k] = 1'b1;
                ready   = !stages_i[k].ld || (k >= LDRDY);
            end
        end
    end

    // An unready youngest match suppresses the bypass entirely.
    assign hit_o   = found & ready;
    assign sel_o   = hit_o ? pick : '0;
    assign stall_o = found & ~ready;

endmodule

// File: rtl/p405s_gpr_hazard_scbd.sv
// GPR hazard scoreboard: tracks NST in-flight destinations, answers bypass
// and stall queries combinationally, and shifts the stage record per edge.
// Optional stall counter output stallCnt is built when P405S_SCBD_PERF_EN
// is defined.
module p405s_gpr_hazard_scbd
    import p405s_scbd_pkg::*;
#(
    parameter int AW    = SCBD_AW,
    parameter int NRP   = SCBD_NRP,
    parameter int NST   = SCBD_NST,
    parameter int LDRDY = SCBD_LDRDY
)(
    input  logic CB,
    input  logic resetCore,
    p405s_gpr_hazard_scbd_if.slave bus
`ifdef P405S_SCBD_PERF_EN
    ,
    output logic [15:0] stallCnt
`endif
);
    scbd_entry_t [NST-1:0] stage_q;
    scbd_entry_t [NST-1:0] stage_d;
    logic [NRP-1:0]        port_hit;
    logic [NRP*NST-1:0]    port_sel;
    logic [NRP-1:0]        port_stall;
    logic                  stall_req;
    logic                  issue_ack;

    for (genvar p = 0; p < NRP; p++) begin : g_port
        p405s_scbd_portcmp #(
            .AW    (AW),
            .NST   (NST),
            .LDRDY (LDRDY)
        ) u_cmp (
            .rd_en_i   (bus.rdEn[p]),
            .rd_addr_i (bus.rdAddr[p*AW +: AW]),
            .stages_i  (stage_q),
            .hit_o     (port_hit[p]),
            .sel_o     (port_sel[p*NST +: NST]),
            .stall_o   (port_stall[p])
        );
    end

    // Reset clears state asynchronously, so bypass/stall fall to zero with it;
    // issueAck only looks at decode and hold while reset is active.
    assign stall_req    = (|port_stall) & ~resetCore;
    assign issue_ack    = bus.dcdValid & ~bus.holdExe & (resetCore | (~stall_req & ~bus.flushAll));
    assign bus.bypHit   = port_hit;
    assign bus.bypSel   = port_sel;
    assign bus.stallReq = stall_req;
    assign bus.issueAck = issue_ack;

    // Next stage record: flush beats hold, hold beats normal shift/issue.
    always_comb begin
        stage_d = stage_q;
        if (bus.flushAll) begin
            for (int k = 0; k < NST; k++) stage_d[k].vld = 1'b0;
        end else if (bus.holdExe) begin
            stage_d[1].vld = 1'b0;
            for (int k = 2; k < NST; k++) stage_d[k] = stage_q[k-1];
        end else begin
            for (int k = 1; k < NST; k++) stage_d[k] = stage_q[k-1];
            if (issue_ack && bus.dcdWrEn) begin
                stage_d[0] = '{vld: 1'b1, addr: SCBD_AW_MAX'(bus.dcdWrAddr), ld: bus.dcdIsLoad};
            end else begin
                stage_d[0] = SCBD_ENTRY_EMPTY;
            end
        end
    end

    // Stage record register.
    always_ff @(posedge CB or posedge resetCore) begin
        if (resetCore) begin
            stage_q <= '0;
        end else begin
            // NOTE: non-blocking so every stage samples its neighbour's pre-edge value.
            stage_q <= stage_d;
        end
    end

`ifdef P405S_SCBD_PERF_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] stall_cnt_d;

    // Saturating count of cycles where decode wanted to issue but was stalled.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bus.dcdValid && stall_req && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge CB or posedge resetCore) begin
        if (resetCore) stall_cnt_q <= '0;
        else           stall_cnt_q <= stall_cnt_d;
    end

    assign stallCnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_p405s_gpr_hazard_scbd.sv
// Directed bench for p405s_gpr_hazard_scbd with an expected-result queue.
// Stall counter checks are included when P405S_SCBD_PERF_EN is defined.
module tb_p405s_gpr_hazard_scbd;
    localparam int AW  = 5;
    localparam int NRP = 3;
    localparam int NST = 4;
    localparam int LDRDY = 2;

    typedef struct packed {
        logic [NRP-1:0]     hit;
        logic [NRP*NST-1:0] sel;
        logic               stall;
        logic               ack;
    } exp_t;

    logic CB = 1'b0;
    logic resetCore = 1'b1;
    int   checks = 0;
    int   failures = 0;
    exp_t  exp_q[$];
    string tag_q[$];
`ifdef P405S_SCBD_PERF_EN
    logic [15:0] stallCnt;
`endif

    p405s_gpr_hazard_scbd_if #(.AW(AW), .NRP(NRP), .NST(NST)) bus ();

    p405s_gpr_hazard_scbd #(.AW(AW), .NRP(NRP), .NST(NST), .LDRDY(LDRDY)) u_dut (
        .CB        (CB),
        .resetCore (resetCore),
        .bus       (bus.slave)
`ifdef P405S_SCBD_PERF_EN
        ,
        .stallCnt  (stallCnt)
`endif
    );

    always #5 CB = ~CB;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1, "watchdog expired");
    end

    task automatic idle();
        bus.dcdValid = 1'b0; bus.dcdWrEn = 1'b0; bus.dcdWrAddr = '0; bus.dcdIsLoad = 1'b0;
        bus.rdEn = '0; bus.rdAddr = '0; bus.holdExe = 1'b0; bus.flushAll = 1'b0;
    endtask

    task automatic issue(input logic we, input logic [AW-1:0] a, input logic ld);
        bus.dcdValid = 1'b1; bus.dcdWrEn = we; bus.dcdWrAddr = a; bus.dcdIsLoad = ld;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        bus.rdEn[p] = 1'b1;
        bus.rdAddr[p*AW +: AW] = a;
    endtask

    task automatic tick();
        @(posedge CB);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [NRP-1:0] hit,
                              input logic [NRP*NST-1:0] sel, input logic stall, input logic ack);
        exp_t e;
        e.hit = hit; e.sel = sel; e.stall = stall; e.ack = ack;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic compare_now();
        exp_t  e;
        string t;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            assert (bus.bypHit === e.hit) else begin
                failures++;
                $error("FAIL %s bypHit got=%b exp=%b", t, bus.bypHit, e.hit);
            end
            checks++;
            assert (bus.bypSel === e.sel) else begin
                failures++;
                $error("FAIL %s bypSel got=%h exp=%h", t, bus.bypSel, e.sel);
            end
            checks++;
            assert (bus.stallReq === e.stall) else begin
                failures++;
                $error("FAIL %s stallReq got=%b exp=%b", t, bus.stallReq, e.stall);
            end
            checks++;
            assert (bus.issueAck === e.ack) else begin
                failures++;
                $error("FAIL %s issueAck got=%b exp=%b", t, bus.issueAck, e.ack);
            end
        end
    endtask

    task automatic compare();
        @(negedge CB);
        compare_now();
    endtask

    task automatic drain();
        idle();
        repeat (NST) tick();
    endtask

    initial begin
        // Reset state: outputs clear, issueAck follows dcdValid & ~holdExe.
        idle();
        issue(1'b1, 5'd5, 1'b0);
        bus.flushAll = 1'b1;
        set_rd(0, 5'd0);
        #1;
        expect_out("reset_ack", 3'b000, 12'h000, 1'b0, 1'b1);
        compare_now();
        bus.holdExe = 1'b1;
        #1;
        expect_out("reset_hold", 3'b000, 12'h000, 1'b0, 1'b0);
        compare_now();
        tick();
        resetCore = 1'b0;
        idle();

        // ALU write to r5, then port A reads r5 from stage 0.
        issue(1'b1, 5'd5, 1'b0);
        expect_out("alu_issue", 3'b000, 12'h000, 1'b0, 1'b1);
        compare();
        tick();
        idle();
        set_rd(0, 5'd5);
        expect_out("alu_byp_s0", 3'b001, 12'h001, 1'b0, 1'b0);
        compare();
        drain();

        // Load to r7: stall in stages 0 and 1, bypass from stage 2.
        issue(1'b1, 5'd7, 1'b1);
        expect_out("ld_issue", 3'b000, 12'h000, 1'b0, 1'b1);
        compare();
        tick();
        issue(1'b1, 5'd1, 1'b0);
        set_rd(1, 5'd7);
        expect_out("ld_stall_s0", 3'b000, 12'h000, 1'b1, 1'b0);
        compare();
        tick();
        expect_out("ld_stall_s1", 3'b000, 12'h000, 1'b1, 1'b0);
        compare();
        tick();
        expect_out("ld_byp_s2", 3'b010, 12'h040, 1'b0, 1'b1);
        compare();
        drain();

        // r3 in stage 0 (ALU) and stage 2 (load): youngest wins.
        issue(1'b1, 5'd3, 1'b1);  tick();
        issue(1'b1, 5'd10, 1'b0); tick();
        issue(1'b1, 5'd3, 1'b0);  tick();
        idle();
        set_rd(0, 5'd10);
        set_rd(2, 5'd3);
        expect_out("youngest_alu", 3'b101, 12'h102, 1'b0, 1'b0);
        compare();
        drain();

        // Unready load r3 in stage 0 with ready r3 in stage 2: must stall.
        issue(1'b1, 5'd3, 1'b0);  tick();
        issue(1'b1, 5'd11, 1'b0); tick();
        issue(1'b1, 5'd3, 1'b1);  tick();
        issue(1'b1, 5'd0, 1'b0);
        set_rd(1, 5'd11);
        set_rd(2, 5'd3);
        expect_out("young_unready", 3'b010, 12'h020, 1'b1, 1'b0);
        compare();
        drain();

        // Hold for two edges with r9 in stage 0 and r20 in stage 1.
        issue(1'b1, 5'd20, 1'b0); tick();
        issue(1'b1, 5'd9, 1'b0);  tick();
        issue(1'b1, 5'd12, 1'b0);
        bus.holdExe = 1'b1;
        set_rd(0, 5'd9);
        set_rd(1, 5'd20);
        expect_out("hold_pre", 3'b011, 12'h021, 1'b0, 1'b0);
        compare();
        tick();
        expect_out("hold_1", 3'b011, 12'h041, 1'b0, 1'b0);
        compare();
        tick();
        bus.holdExe = 1'b0;
        bus.dcdValid = 1'b0;
        set_rd(2, 5'd12);
        expect_out("hold_2", 3'b011, 12'h081, 1'b0, 1'b0);
        compare();
        drain();

        // Flush with dcdValid in the same cycle.
        issue(1'b1, 5'd4, 1'b0); tick();
        issue(1'b1, 5'd6, 1'b1); tick();
        issue(1'b1, 5'd8, 1'b0);
        bus.flushAll = 1'b1;
        set_rd(0, 5'd4);
        expect_out("flush_pre", 3'b001, 12'h002, 1'b0, 1'b0);
        compare();
        tick();
        idle();
        set_rd(0, 5'd4);
        set_rd(1, 5'd6);
        set_rd(2, 5'd8);
        expect_out("flush_post", 3'b000, 12'h000, 1'b0, 1'b0);
        compare();
        drain();

        // Write-disabled issue stores nothing.
        issue(1'b0, 5'd21, 1'b1); tick();
        idle();
        set_rd(0, 5'd21);
        expect_out("wren_off", 3'b000, 12'h000, 1'b0, 1'b0);
        compare();
        drain();

        // Four valid entries, then asynchronous reset between edges.
        issue(1'b1, 5'd1, 1'b0);  tick();
        issue(1'b1, 5'd2, 1'b0);  tick();
        issue(1'b1, 5'd13, 1'b0); tick();
        issue(1'b1, 5'd14, 1'b0); tick();
        idle();
        set_rd(0, 5'd1);
        set_rd(1, 5'd13);
        set_rd(2, 5'd14);
        expect_out("full_pipe", 3'b111, 12'h128, 1'b0, 1'b0);
        compare();
        #1;
        resetCore = 1'b1;
        bus.dcdValid = 1'b1;
        #1;
        expect_out("async_reset", 3'b000, 12'h000, 1'b0, 1'b1);
        compare_now();
        tick();
        resetCore = 1'b0;
        bus.dcdValid = 1'b0;
        expect_out("after_reset", 3'b000, 12'h000, 1'b0, 1'b0);
        compare();

`ifdef P405S_SCBD_PERF_EN
        checks++;
        assert (stallCnt === 16'd0) else begin
            failures++;
            $error("FAIL cnt_reset stallCnt got=%h exp=%h", stallCnt, 16'd0);
        end
        idle();
        issue(1'b1, 5'd7, 1'b1); tick();
        issue(1'b1, 5'd2, 1'b0);
        bus.holdExe = 1'b1;
        set_rd(0, 5'd7);
        repeat (10) tick();
        checks++;
        assert (stallCnt === 16'd10) else begin
            failures++;
            $error("FAIL cnt_10 stallCnt got=%h exp=%h", stallCnt, 16'd10);
        end
        repeat (65530) tick();
        checks++;
        assert (stallCnt === 16'hFFFF) else begin
            failures++;
            $error("FAIL cnt_sat stallCnt got=%h exp=%h", stallCnt, 16'hFFFF);
        end
        idle();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/p405s_gpr_hazard_scbd.md
P405S_GPR_HAZARD_SCBD -- requirements
Module: p405s_gpr_hazard_scbd

Interface
REQ-001 SHALL have parameter AW, default 5: register-file address width.
REQ-002 SHALL have parameter NRP, default 3: read ports compared (A, B, S).
REQ-003 SHALL have parameter NST, default 4: tracked in-flight stages; stage 0 = exe, stage NST-1 = last before file write.
REQ-004 SHALL have parameter LDRDY, default 2: first stage index at which load data is bypassable.
REQ-005 SHALL have ports: CB in 1 (clock, rising edge); resetCore in 1 (asynchronous, active-high reset).
REQ-006 SHALL have ports: dcdValid in 1 (dcd holds an instruction); dcdWrEn in 1 (instruction writes file); dcdWrAddr in AW (destination); dcdIsLoad in 1 (destination written by load).
REQ-007 SHALL have ports: rdEn in NRP (per-port read request); rdAddr in NRP*AW (port p at bits p*AW+:AW).
REQ-008 SHALL have ports: holdExe in 1 (external exe hold); flushAll in 1 (kill all in-flight entries).
REQ-009 SHALL have outputs: bypHit NRP (port sources from a stage); bypSel NRP*NST (one-hot stage select per port); stallReq 1 (dcd must not issue); issueAck 1 (dcd entry accepted this cycle).

Function
REQ-010 SHALL hold per stage k: vld[k], addr[k] (AW), ld[k]; entry ready when ~ld[k] or k>=LDRDY.
REQ-011 SHALL compare each enabled port only against valid stages; match[p][k] = rdEn[p] & vld[k] & (rdAddr[p]==addr[k]); combinational from current state.
REQ-012 SHALL select, per port, the lowest-index (youngest) matching stage; bypSel one-hot at that stage, bypHit=1, else all zero.
REQ-013 SHALL assert stallReq when any port's youngest match is not ready; an older ready match never masks a younger unready one.
REQ-014 SHALL drive bypHit=0 and bypSel=0 for a port whose youngest match is not ready.
REQ-015 SHALL compute issueAck = dcdValid & ~stallReq & ~holdExe & ~flushAll.
REQ-016 SHALL on each edge with flushAll=0 and holdExe=0: shift stage k to k+1 for k<NST-1; stage NST-1 retires; stage 0 loads {dcdWrEn,dcdWrAddr,dcdIsLoad} if issueAck else vld[0]=0.
REQ-017 SHALL on each edge with holdExe=1 and flushAll=0: keep stage 0 unchanged, set vld[1]=0, shift stages 1..NST-2 into 2..NST-1.
REQ-018 SHALL on flushAll=1 clear all vld on the next edge; flush beats hold, issue and shift in the same cycle.
REQ-019 SHALL ignore dcdWrAddr/dcdIsLoad when dcdWrEn=0 (entry stored with vld=0).
REQ-020 SHALL produce bypass and stall outputs with zero-cycle latency relative to rdAddr; state updates take effect one cycle later.

Reset
REQ-021 SHALL on resetCore=1 immediately clear all vld, addr and ld to 0, independent of CB.
REQ-022 SHALL drive bypHit=0, bypSel=0, stallReq=0 and issueAck=dcdValid & ~holdExe while reset is active; no state updates while reset is asserted.

Configuration
REQ-023 SHALL with macro P405S_SCBD_PERF_EN defined add output stallCnt 16 bits, incremented on each edge with dcdValid & stallReq, saturating at 16'hFFFF, cleared by resetCore.
REQ-024 SHALL without P405S_SCBD_PERF_EN have no stallCnt port and no counter logic; all other behaviour identical.

Structure
REQ-025 SHALL place default AW/NRP/NST/LDRDY values and the stage-entry record (vld, addr, ld) in shared package p405s_scbd_pkg.
REQ-026 SHALL implement per-port compare and youngest-ready pick in sub-module p405s_scbd_portcmp, instantiated NRP times.

Verification
REQ-027 SHALL cover: ALU write to r5 issued, next cycle rdAddr A=5 -> bypHit[0]=1, bypSel A=4'b0001, stallReq=0.
REQ-028 SHALL cover: load to r7 issued, next cycle port B reads 7 -> stallReq=1, issueAck=0; after two more edges (stage 2) -> stallReq=0, bypSel B=4'b0100.
REQ-029 SHALL cover: r3 written in stage 0 (ALU) and stage 2 (load), port S reads 3 -> bypSel S=4'b0001 (youngest); same with stage 0 unready load -> stallReq=1.
REQ-030 SHALL cover: holdExe=1 for 2 cycles with r9 in stage 0 -> stage 0 keeps r9, port A=9 still hits stage 0; stage 1 empty; issueAck=0.
REQ-031 SHALL cover: flushAll with dcdValid=1 in same cycle -> next cycle all bypHit=0, stallReq=0, no entry issued.
REQ-032 SHALL cover: resetCore pulse mid-pipeline with 4 valid entries -> outputs clear without a CB edge; with P405S_SCBD_PERF_EN, stallCnt saturates at 16'hFFFF under a held stall.
